// File: rtl/key_schedule_ctrl_pkg.sv
// Shared types, constants and byte-level helpers for the AES-128 key expander.
package key_schedule_ctrl_pkg;

  localparam int unsigned AES_NR           = 10;
  localparam int unsigned AES_NK_ROUNDKEYS = 11;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rn);
    logic [7:0] r;
    unique case (rn)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_keygen.sv
// One combinational AES-128 key-expansion round: rk[rn+1] from rk[rn].
module key_schedule_ctrl_keygen
  import key_schedule_ctrl_pkg::*;
(
  input  round_key_t kin_i,
  input  logic [3:0] rn_i,
  output round_key_t kout_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = kin_i;

  // RotWord then SubWord, rcon folded into the top byte.
  assign temp = {sbox(w3[23:16]) ^ rcon(rn_i), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign kout_o = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key expander with an 11-entry round-key file and registered read port.
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
#(
  parameter int unsigned NR           = 10,
  parameter bit          RD_ZERO_MISS = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  output logic         done,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_data,
  output logic         rd_valid,
  output logic         rd_hit
);

  if (NR != AES_NR) begin : g_bad_nr
    $fatal(1, "key_schedule_ctrl supports only NR=10 (AES-128)");
  end

  localparam logic [3:0] LAST_IDX = 4'(AES_NR);
  localparam logic [3:0] LAST_CNT = 4'(AES_NR - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [3:0] gen_cnt_q;
  logic       keys_valid_q;
  logic       done_q;
  round_key_t rk_q [AES_NK_ROUNDKEYS];

  round_key_t rd_data_q;
  logic       rd_valid_q;
  logic       rd_hit_q;

  round_key_t kgen_in;
  round_key_t kgen_out;
  logic       accept;
  logic       wr_en;
  logic [3:0] wr_idx;
  logic       idx_in_range;
  logic       rd_hit_d;

  assign key_ready = (state_q != StExpand);
  assign busy      = (state_q == StExpand);
  assign accept    = key_valid && key_ready;
  assign kgen_in   = rk_q[cnt_q];

  key_schedule_ctrl_keygen u_keygen (
    .kin_i  (kgen_in),
    .rn_i   (cnt_q),
    .kout_o (kgen_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      gen_cnt_q    <= '0;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < AES_NK_ROUNDKEYS; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            rk_q[0]      <= key_in;
            cnt_q        <= '0;
            gen_cnt_q    <= 4'd1;
            keys_valid_q <= 1'b0;
            state_q      <= StExpand;
          end
        end
        StExpand: begin
          rk_q[cnt_q + 4'd1] <= kgen_out;
          cnt_q              <= cnt_q + 4'd1;
          gen_cnt_q          <= gen_cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_q      <= StDone;
            keys_valid_q <= 1'b1;
            done_q       <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Entry written on this edge, if any; a read of it is reported as a miss.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    if (state_q == StExpand) begin
      wr_en  = 1'b1;
      wr_idx = cnt_q + 4'd1;
    end else if (accept) begin
      wr_en  = 1'b1;
      wr_idx = '0;
    end
  end

  assign idx_in_range = (rd_idx <= LAST_IDX);
  assign rd_hit_d     = idx_in_range && (rd_idx < gen_cnt_q) && !(wr_en && (rd_idx == wr_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else if (rd_en) begin
      rd_valid_q <= 1'b1;
      rd_hit_q   <= rd_hit_d;
      if (rd_hit_d || (!RD_ZERO_MISS && idx_in_range)) begin
        rd_data_q <= rk_q[rd_idx];
      end else begin
        rd_data_q <= '0;
      end
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign keys_valid = keys_valid_q;
  assign done       = done_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_hit     = rd_hit_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed and random bench for key_schedule_ctrl against an independent AES-128 key-schedule model.
module tb_key_schedule_ctrl;

  logic         clk;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic         done;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         rd_hit;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]   sbox_m   [256];
  logic [7:0]   rcon_m   [10];
  logic [127:0] model_rk [11];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_schedule_ctrl #(
    .NR           (10),
    .RD_ZERO_MISS (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .done       (done),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_hit     (rd_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from GF(2^8) inversion plus the affine map, rcon by repeated doubling.
  task automatic build_tables;
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_m[x] = s;
    end
    rcon_m[0] = 8'h01;
    for (int i = 1; i < 10; i++) rcon_m[i] = gmul(rcon_m[i-1], 8'h02);
  endtask

  task automatic compute_model(input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, t;
    model_rk[0] = k;
    for (int r = 0; r < 10; r++) begin
      {w0, w1, w2, w3} = model_rk[r];
      t = {sbox_m[w3[23:16]], sbox_m[w3[15:8]], sbox_m[w3[7:0]], sbox_m[w3[31:24]]};
      t[31:24] = t[31:24] ^ rcon_m[r];
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      model_rk[r+1] = {w0, w1, w2, w3};
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx);
    rd_en  = 1'b1;
    rd_idx = idx;
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    tests_run++;
    if ({key_ready, busy, keys_valid, done, rd_valid, rd_hit} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL reset_flags got %b exp 100000",
               {key_ready, busy, keys_valid, done, rd_valid, rd_hit});
    end
    tests_run++;
    if (rd_data !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_rd_data got %h exp 0", rd_data);
    end
    #4;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fips;
    int n;
    accept_key(FIPS_KEY);
    tests_run++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fips_busy got busy=%b ready=%b exp 1 0", busy, key_ready);
    end
    wait_done(n);
    tests_run++;
    if (n != 10 || keys_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL fips_done_latency got %0d kv=%b exp 10 kv=1", n, keys_valid);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || keys_valid !== 1'b1 || key_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL fips_done_pulse got done=%b kv=%b ready=%b exp 0 1 1",
               done, keys_valid, key_ready);
    end
    rd(4'd1);
    tests_run++;
    if (rd_data !== FIPS_RK1 || rd_hit !== 1'b1 || rd_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL fips_rk1 got %h hit=%b exp %h hit=1", rd_data, rd_hit, FIPS_RK1);
    end
    rd(4'd10);
    tests_run++;
    if (rd_data !== FIPS_RK10 || rd_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL fips_rk10 got %h hit=%b exp %h hit=1", rd_data, rd_hit, FIPS_RK10);
    end
    rd(4'd0);
    tests_run++;
    if (rd_data !== FIPS_KEY || rd_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL fips_rk0 got %h hit=%b exp %h hit=1", rd_data, rd_hit, FIPS_KEY);
    end
    tick();
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data !== FIPS_KEY || rd_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL fips_rd_hold got v=%b %h hit=%b exp v=0 %h hit=1",
               rd_valid, rd_data, rd_hit, FIPS_KEY);
    end
  endtask

  task automatic test_zero_key;
    int n;
    accept_key(128'h0);
    wait_done(n);
    tests_run++;
    if (n != 10) begin
      tests_failed++;
      $display("FAIL zero_latency got %0d exp 10", n);
    end
    rd(4'd1);
    tests_run++;
    if (rd_data !== ZERO_RK1 || rd_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_rk1 got %h hit=%b exp %h hit=1", rd_data, rd_hit, ZERO_RK1);
    end
    rd(4'd10);
    tests_run++;
    if (rd_data !== ZERO_RK10 || rd_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_rk10 got %h hit=%b exp %h hit=1", rd_data, rd_hit, ZERO_RK10);
    end
  endtask

  task automatic test_read_during_expand;
    int n;
    compute_model(FIPS_KEY);
    accept_key(FIPS_KEY);
    tick();
    tick();
    rd(4'd2);
    tests_run++;
    if (rd_data !== model_rk[2] || rd_hit !== 1'b1 || rd_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL expand_rd2 got %h hit=%b exp %h hit=1", rd_data, rd_hit, model_rk[2]);
    end
    rd(4'd7);
    tests_run++;
    if (rd_data !== 128'h0 || rd_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL expand_rd7 got %h hit=%b exp 0 hit=0", rd_data, rd_hit);
    end
    wait_done(n);
    tests_run++;
    if (n != 6) begin
      tests_failed++;
      $display("FAIL expand_remaining got %0d exp 6", n);
    end
    rd(4'd12);
    tests_run++;
    if (rd_data !== 128'h0 || rd_hit !== 1'b0 || rd_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_rd12 got %h hit=%b v=%b exp 0 0 1", rd_data, rd_hit, rd_valid);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [127:0] ka, kb, a10, b10;
    ka = 128'h000102030405060708090a0b0c0d0e0f;
    kb = 128'hfedcba98765432100123456789abcdef;
    compute_model(kb);
    b10 = model_rk[10];
    compute_model(ka);
    a10 = model_rk[10];
    key_in    = ka;
    key_valid = 1'b1;
    tick();
    key_in = kb;
    tick();
    tests_run++;
    if (key_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_backpressure got ready=%b busy=%b exp 0 1", key_ready, busy);
    end
    rd(4'd0);
    tests_run++;
    if (rd_data !== ka || rd_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_key_kept got %h hit=%b exp %h hit=1", rd_data, rd_hit, ka);
    end
    wait_done(n);
    tests_run++;
    if (n != 8 || keys_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first_done got %0d kv=%b exp 8 kv=1", n, keys_valid);
    end
    rd(4'd10);
    key_valid = 1'b0;
    tests_run++;
    if (rd_data !== a10 || rd_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_old_rk10 got %h hit=%b exp %h hit=1", rd_data, rd_hit, a10);
    end
    tests_run++;
    if (keys_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_restart got kv=%b busy=%b exp 0 1", keys_valid, busy);
    end
    wait_done(n);
    tests_run++;
    if (n != 10) begin
      tests_failed++;
      $display("FAIL b2b_second_latency got %0d exp 10", n);
    end
    rd(4'd10);
    tests_run++;
    if (rd_data !== b10 || rd_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_new_rk10 got %h hit=%b exp %h hit=1", rd_data, rd_hit, b10);
    end
  endtask

  task automatic test_async_reset;
    int n;
    logic [127:0] k2;
    k2 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    accept_key(FIPS_KEY);
    repeat (4) tick();
    rd(4'd0);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== FIPS_KEY) begin
      tests_failed++;
      $display("FAIL arst_pre_read got v=%b %h exp v=1 %h", rd_valid, rd_data, FIPS_KEY);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({key_ready, busy, keys_valid, done, rd_valid, rd_hit} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL arst_flags got %b exp 100000",
               {key_ready, busy, keys_valid, done, rd_valid, rd_hit});
    end
    tests_run++;
    if (rd_data !== 128'h0) begin
      tests_failed++;
      $display("FAIL arst_rd_data got %h exp 0", rd_data);
    end
    #2;
    rst_n = 1'b1;
    tick();
    rd(4'd0);
    tests_run++;
    if (rd_data !== 128'h0 || rd_hit !== 1'b0 || key_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL arst_rd0 got %h hit=%b ready=%b exp 0 0 1", rd_data, rd_hit, key_ready);
    end
    compute_model(k2);
    accept_key(k2);
    wait_done(n);
    tests_run++;
    if (n != 10) begin
      tests_failed++;
      $display("FAIL arst_fresh_latency got %0d exp 10", n);
    end
    rd(4'd10);
    tests_run++;
    if (rd_data !== model_rk[10] || rd_hit !== 1'b1) begin
      tests_failed++;
      $display("FAIL arst_fresh_rk10 got %h hit=%b exp %h hit=1",
               rd_data, rd_hit, model_rk[10]);
    end
  endtask

  task automatic test_random;
    logic [127:0] k, exp_data;
    logic [3:0]   idx;
    logic         en, exp_hit;
    for (int it = 0; it < 200; it++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      compute_model(k);
      accept_key(k);
      // Edge e (1..10) after accept sees gen_cnt == e before it; 11 once done.
      for (int e = 1; e <= 12; e++) begin
        en     = 1'($urandom_range(0, 1));
        idx    = 4'($urandom_range(0, 15));
        rd_en  = en;
        rd_idx = idx;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (rd_valid !== en) begin
          tests_failed++;
          $display("FAIL rand_valid key %0d edge %0d got %b exp %b", it, e, rd_valid, en);
        end
        if (en) begin
          exp_hit  = (idx <= 4'd10) && (int'(idx) < ((e > 11) ? 11 : e));
          exp_data = exp_hit ? model_rk[idx] : 128'h0;
          tests_run++;
          if (rd_hit !== exp_hit || rd_data !== exp_data) begin
            tests_failed++;
            $display("FAIL rand_read key %0d edge %0d idx %0d got %h hit=%b exp %h hit=%b",
                     it, e, idx, rd_data, rd_hit, exp_data, exp_hit);
          end
        end
        if (e <= 10) begin
          tests_run++;
          if (done !== (e == 10) || keys_valid !== (e == 10)) begin
            tests_failed++;
            $display("FAIL rand_done key %0d edge %0d got done=%b kv=%b exp %b",
                     it, e, done, keys_valid, (e == 10));
          end
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    key_in    = '0;
    key_valid = 1'b0;
    rd_en     = 1'b0;
    rd_idx    = '0;
    build_tables();
    test_reset();
    test_fips();
    test_zero_key();
    test_read_during_expand();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
